// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared vector register file constants and types
//
// Constants shared by the VRF and its writeback scheduler.
//   VRF_ADDR_W   : register address width
//   VRF_NUM_REGS : number of vector registers (one scoreboard bit each)
//   VRF_DATA_W   : vector register width
package vrf_pkg;

    localparam int VRF_ADDR_W   = 5;
    localparam int VRF_NUM_REGS = 32;
    localparam int VRF_DATA_W   = 64;

    typedef logic [VRF_ADDR_W-1:0] vrf_addr_t;

    // One-hot mask selecting a single register in the scoreboard.
    function automatic logic [VRF_NUM_REGS-1:0] reg_mask(input vrf_addr_t a);
        reg_mask    = '0;
        reg_mask[a] = 1'b1;
    endfunction

endpackage

// File: rtl/vrf_wb_sched_if.sv
// rtl/vrf_wb_sched_if.sv - issue, writeback request and VRF write port bundle
//
// Signals:
//   iss_valid/iss_vd/iss_vs1/iss_vs2/iss_uses_vs1/iss_uses_vs2 : issue stage query
//   iss_ready                                                  : issue may proceed
//   req_valid/req_wa/req_wd                                    : packed FU writeback requests
//   req_ready                                                  : one-hot grant
//   wen/wa/wd                                                  : registered VRF write port
//   busy/idle/wb_err                                           : scoreboard status
// Modports: master = issue stage + FUs + VRF side, slave = scheduler.
interface vrf_wb_sched_if
    import vrf_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = VRF_DATA_W,
    parameter int ADDR_W  = VRF_ADDR_W
);

    logic                      iss_valid;
    logic [ADDR_W-1:0]         iss_vd;
    logic [ADDR_W-1:0]         iss_vs1;
    logic [ADDR_W-1:0]         iss_vs2;
    logic                      iss_uses_vs1;
    logic                      iss_uses_vs2;
    logic                      iss_ready;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_wa;
    logic [NUM_REQ*DATA_W-1:0] req_wd;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      wen;
    logic [ADDR_W-1:0]         wa;
    logic [DATA_W-1:0]         wd;
    logic [VRF_NUM_REGS-1:0]   busy;
    logic                      idle;
    logic                      wb_err;

    modport master (
        output iss_valid, iss_vd, iss_vs1, iss_vs2, iss_uses_vs1, iss_uses_vs2,
        output req_valid, req_wa, req_wd,
        input  iss_ready, req_ready, wen, wa, wd, busy, idle, wb_err
    );

    modport slave (
        input  iss_valid, iss_vd, iss_vs1, iss_vs2, iss_uses_vs1, iss_uses_vs2,
        input  req_valid, req_wa, req_wd,
        output iss_ready, req_ready, wen, wa, wd, busy, idle, wb_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with last-granted pointer
//
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   req      : request vector
//   advance  : move the pointer to the current winner (when one exists)
//   gnt      : one-hot combinational grant, subset of req
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last;

    // Search begins one past the last winner, so the last winner has lowest priority.
    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(last) + off) % N;
            if ((gnt == '0) && req[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
    end

    // Reset to N-1 so requester 0 is first in line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= PW'(N - 1);
        end else if (advance && (gnt != '0)) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    last <= PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/vrf_wb_sched.sv
// rtl/vrf_wb_sched.sv - VRF writeback scheduler and register busy scoreboard
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : vrf_wb_sched_if.slave (issue query, FU writeback requests,
//          registered VRF write port, scoreboard status)
module vrf_wb_sched
    import vrf_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = VRF_DATA_W,
    parameter int ADDR_W  = VRF_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    vrf_wb_sched_if.slave  bus
);

    logic [NUM_REQ-1:0]      gnt;
    logic                    transfer;
    logic [ADDR_W-1:0]       win_wa;
    logic [DATA_W-1:0]       win_wd;

    logic                    wen_q;
    logic [ADDR_W-1:0]       wa_q;
    logic [DATA_W-1:0]       wd_q;
    logic [VRF_NUM_REGS-1:0] busy_q;
    logic                    err_q;

    logic [VRF_NUM_REGS-1:0] clr_mask;
    logic [VRF_NUM_REGS-1:0] set_mask;
    logic [VRF_NUM_REGS-1:0] eff_busy;
    logic                    iss_ok;
    logic                    iss_set;
    logic                    err_hit;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (transfer),
        .gnt     (gnt)
    );

    assign bus.req_ready = gnt;
    assign transfer      = |(bus.req_valid & gnt);

    always_comb begin
        win_wa = '0;
        win_wd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_wa = bus.req_wa[i*ADDR_W +: ADDR_W];
                win_wd = bus.req_wd[i*DATA_W +: DATA_W];
            end
        end
    end

    // The register being written this cycle is bypassed by the VRF, so it is
    // not a hazard for an instruction issuing in the same cycle.
    assign clr_mask = wen_q ? reg_mask(vrf_addr_t'(wa_q)) : '0;
    assign eff_busy = busy_q & ~clr_mask;

    assign iss_ok = !eff_busy[bus.iss_vd]
                  && !(bus.iss_uses_vs1 && eff_busy[bus.iss_vs1])
                  && !(bus.iss_uses_vs2 && eff_busy[bus.iss_vs2]);
    assign iss_set  = bus.iss_valid && iss_ok;
    assign set_mask = iss_set ? reg_mask(vrf_addr_t'(bus.iss_vd)) : '0;

    // A write to a register nobody is waiting on means a lost or duplicate
    // writeback; a same-cycle issue to that register legitimises it.
    assign err_hit = transfer && !busy_q[win_wa]
                   && !(iss_set && (bus.iss_vd == win_wa));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q  <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wen_q <= transfer;
            if (transfer) begin
                wa_q <= win_wa;
                wd_q <= win_wd;
            end
            // Set is applied after clear so a same-register collision stays busy.
            busy_q <= (busy_q & ~clr_mask) | set_mask;
            if (err_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.iss_ready = iss_ok;
    assign bus.wen       = wen_q;
    assign bus.wa        = wa_q;
    assign bus.wd        = wd_q;
    assign bus.busy      = busy_q;
    assign bus.idle      = (busy_q == '0) && !wen_q;
    assign bus.wb_err    = err_q;

endmodule
